// File: rtl/control_pipe.sv
// Pipelined MIPS main controller: decodes op/funct in Decode and shifts the control word through E, M and W.
// Optional CTRL_PERF_EN adds retired-instruction and flush-bubble counters.
module control_pipe (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       equalD,
    input  logic       flushE,
    output logic       pcsrcD,
    output logic       branchD,
    output logic       illegalD,
    output logic       regdstE,
    output logic       alusrcE,
    output logic [2:0] alucontrolE,
    output logic       regwriteE,
    output logic       memtoregE,
    output logic       memwriteM,
    output logic       regwriteM,
    output logic       memtoregM,
    output logic       regwriteW,
    output logic       memtoregW
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0] retired,
    output logic [31:0] bubbles
`endif
);

    logic       regwriteD;
    logic       regdstD;
    logic       alusrcD;
    logic       memwriteD;
    logic       memtoregD;
    logic [2:0] alucontrolD;
    logic       memwriteE;

    // Unsupported encodings decode to an all-zero bubble word.
    always_comb begin
        regwriteD   = 1'b0;
        regdstD     = 1'b0;
        alusrcD     = 1'b0;
        branchD     = 1'b0;
        memwriteD   = 1'b0;
        memtoregD   = 1'b0;
        alucontrolD = 3'b000;
        illegalD    = 1'b0;
        case (op)
            6'b000000: begin
                if (funct != 6'b000000) begin
                    regwriteD = 1'b1;
                    regdstD   = 1'b1;
                    case (funct)
                        6'b100000: alucontrolD = 3'b010;
                        6'b100010: alucontrolD = 3'b110;
                        6'b100100: alucontrolD = 3'b000;
                        6'b100101: alucontrolD = 3'b001;
                        6'b101010: alucontrolD = 3'b111;
                        default: begin
                            regwriteD = 1'b0;
                            regdstD   = 1'b0;
                            illegalD  = 1'b1;
                        end
                    endcase
                end
            end
            6'b100011: begin
                regwriteD   = 1'b1;
                alusrcD     = 1'b1;
                memtoregD   = 1'b1;
                alucontrolD = 3'b010;
            end
            6'b101011: begin
                alusrcD     = 1'b1;
                memwriteD   = 1'b1;
                alucontrolD = 3'b010;
            end
            6'b000100: begin
                branchD     = 1'b1;
                alucontrolD = 3'b110;
            end
            6'b001000: begin
                regwriteD   = 1'b1;
                alusrcD     = 1'b1;
                alucontrolD = 3'b010;
            end
            default: illegalD = 1'b1;
        endcase
    end

    assign pcsrcD = branchD & equalD;

    always_ff @(posedge clk) begin
        if (reset || flushE) begin
            regwriteE   <= 1'b0;
            regdstE     <= 1'b0;
            alusrcE     <= 1'b0;
            memwriteE   <= 1'b0;
            memtoregE   <= 1'b0;
            alucontrolE <= 3'b000;
        end else begin
            regwriteE   <= regwriteD;
            regdstE     <= regdstD;
            alusrcE     <= alusrcD;
            memwriteE   <= memwriteD;
            memtoregE   <= memtoregD;
            alucontrolE <= alucontrolD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regwriteM <= 1'b0;
            memwriteM <= 1'b0;
            memtoregM <= 1'b0;
            regwriteW <= 1'b0;
            memtoregW <= 1'b0;
        end else begin
            regwriteM <= regwriteE;
            memwriteM <= memwriteE;
            memtoregM <= memtoregE;
            regwriteW <= regwriteM;
            memtoregW <= memtoregM;
        end
    end

`ifdef CTRL_PERF_EN
    logic validD;
    logic validE;
    logic validM;
    logic validW;

    // Every legal non-NOP instruction sets at least one of these three bits.
    assign validD = regwriteD | memwriteD | branchD;

    always_ff @(posedge clk) begin
        if (reset) begin
            validE  <= 1'b0;
            validM  <= 1'b0;
            validW  <= 1'b0;
            retired <= 32'd0;
            bubbles <= 32'd0;
        end else begin
            validE  <= flushE ? 1'b0 : validD;
            validM  <= validE;
            validW  <= validM;
            if (validW)
                retired <= retired + 32'd1;
            if (flushE)
                bubbles <= bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_control_pipe.sv
// Directed self-checking bench for control_pipe; perf counter checks compile in when CTRL_PERF_EN is defined.
module tb_control_pipe;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       equalD;
    logic       flushE;
    logic       pcsrcD;
    logic       branchD;
    logic       illegalD;
    logic       regdstE;
    logic       alusrcE;
    logic [2:0] alucontrolE;
    logic       regwriteE;
    logic       memtoregE;
    logic       memwriteM;
    logic       regwriteM;
    logic       memtoregM;
    logic       regwriteW;
    logic       memtoregW;
`ifdef CTRL_PERF_EN
    logic [31:0] retired;
    logic [31:0] bubbles;
`endif

    int vectors = 0;
    int miscompares = 0;

    control_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .equalD      (equalD),
        .flushE      (flushE),
        .pcsrcD      (pcsrcD),
        .branchD     (branchD),
        .illegalD    (illegalD),
        .regdstE     (regdstE),
        .alusrcE     (alusrcE),
        .alucontrolE (alucontrolE),
        .regwriteE   (regwriteE),
        .memtoregE   (memtoregE),
        .memwriteM   (memwriteM),
        .regwriteM   (regwriteM),
        .memtoregM   (memtoregM),
        .regwriteW   (regwriteW),
        .memtoregW   (memtoregW)
`ifdef CTRL_PERF_EN
        ,
        .retired     (retired),
        .bubbles     (bubbles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // E word packs {regwrite, memtoreg, regdst, alusrc, alucontrol}.
    wire [6:0] eWord = {regwriteE, memtoregE, regdstE, alusrcE, alucontrolE};
    wire [2:0] mWord = {regwriteM, memtoregM, memwriteM};
    wire [1:0] wWord = {regwriteW, memtoregW};

    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                                 input logic eq, input logic fl, input logic rst);
        op     = o;
        funct  = f;
        equalD = eq;
        flushE = fl;
        reset  = rst;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic [5:0] sweepFunct [5];
    logic [2:0] sweepAlu   [5];

    initial begin
        sweepFunct = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        sweepAlu   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("reset1 E", {25'd0, eWord}, 32'd0);
        tick();
        checkOutput("reset2 E", {25'd0, eWord}, 32'd0);
        checkOutput("reset2 M", {29'd0, mWord}, 32'd0);
        checkOutput("reset2 W", {30'd0, wWord}, 32'd0);

        // lw walks through E, M and W.
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("lw E", {25'd0, eWord}, 32'b1101010);
        applyStimulus(OP_R, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("lw M", {29'd0, mWord}, 32'b110);
        checkOutput("nop E", {25'd0, eWord}, 32'd0);
        tick();
        checkOutput("lw W", {30'd0, wWord}, 32'b11);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(OP_R, sweepFunct[i], 1'b0, 1'b0, 1'b0);
            checkOutput("rtype illegal", {31'd0, illegalD}, 32'd0);
            tick();
            checkOutput("rtype E", {25'd0, eWord}, {25'd0, 4'b1010, sweepAlu[i]});
        end

        applyStimulus(OP_BEQ, 6'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("beq taken pcsrc", {31'd0, pcsrcD}, 32'd1);
        checkOutput("beq branchD", {31'd0, branchD}, 32'd1);
        applyStimulus(OP_BEQ, 6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("beq not taken pcsrc", {31'd0, pcsrcD}, 32'd0);
        tick();
        checkOutput("beq E", {25'd0, eWord}, 32'b0000110);

        // Flushed sw must never reach memory.
        applyStimulus(OP_SW, 6'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("flushed sw E", {25'd0, eWord}, 32'd0);
        applyStimulus(OP_R, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("flushed sw M", {29'd0, mWord}, 32'd0);
        applyStimulus(OP_SW, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("sw E", {25'd0, eWord}, 32'b0001010);
        applyStimulus(OP_R, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("sw M", {29'd0, mWord}, 32'b001);

        // A flush only bubbles Execute; the older lw keeps moving.
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(OP_ADDI, 6'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("flush E", {25'd0, eWord}, 32'd0);
        checkOutput("older lw M", {29'd0, mWord}, 32'b110);
        applyStimulus(OP_ADDI, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("addi E", {25'd0, eWord}, 32'b1001010);
        checkOutput("flush M", {29'd0, mWord}, 32'd0);
        checkOutput("older lw W", {30'd0, wWord}, 32'b11);

        applyStimulus(6'b111111, 6'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("bad op illegal", {31'd0, illegalD}, 32'd1);
        checkOutput("bad op pcsrc", {31'd0, pcsrcD}, 32'd0);
        tick();
        checkOutput("bad op E", {25'd0, eWord}, 32'd0);
        applyStimulus(OP_R, 6'b000001, 1'b0, 1'b0, 1'b0);
        checkOutput("bad funct illegal", {31'd0, illegalD}, 32'd1);
        tick();
        checkOutput("bad funct E", {25'd0, eWord}, 32'd0);
        applyStimulus(OP_R, 6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("nop illegal", {31'd0, illegalD}, 32'd0);

        // Mid-stream reset drops everything in flight.
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(OP_SW, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(OP_ADDI, 6'd0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("midreset E", {25'd0, eWord}, 32'd0);
        checkOutput("midreset M", {29'd0, mWord}, 32'd0);
        checkOutput("midreset W", {30'd0, wWord}, 32'd0);
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("flush+reset E", {25'd0, eWord}, 32'd0);

`ifdef CTRL_PERF_EN
        checkOutput("perf retired reset", retired, 32'd0);
        checkOutput("perf bubbles reset", bubbles, 32'd0);
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(OP_R, 6'b100000, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(OP_SW, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(OP_BEQ, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(OP_ADDI, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(OP_R, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("perf retired", retired, 32'd5);
        applyStimulus(OP_R, 6'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        applyStimulus(OP_R, 6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("perf bubbles", bubbles, 32'd2);
        checkOutput("perf retired hold", retired, 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
